// File: rtl/div_unit.sv
// Multi-cycle restoring radix-2 divider (DIV/DIVU) for the EX stage; returns {remainder, quotient}.
// Optional DIV_BYZERO_FLAG_EN adds a registered divzero_o flag alongside ready_o.
module div_unit #(
  parameter int unsigned DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  signed_div_i,
  input  logic [DATA_W-1:0]     opdata1_i,
  input  logic [DATA_W-1:0]     opdata2_i,
  input  logic                  start_i,
  input  logic                  annul_i,
  output logic [2*DATA_W-1:0]   result_o,
  output logic                  ready_o
`ifdef DIV_BYZERO_FLAG_EN
  ,
  output logic                  divzero_o
`endif
);

  localparam int unsigned CNT_W = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {
    S_FREE   = 2'd0,
    S_BYZERO = 2'd1,
    S_ON     = 2'd2,
    S_END    = 2'd3
  } state_e;

  state_e                state_q,    state_d;
  logic [CNT_W-1:0]      cnt_q,      cnt_d;
  logic [DATA_W-1:0]     quot_q,     quot_d;
  logic [DATA_W-1:0]     rem_q,      rem_d;
  logic [DATA_W-1:0]     divisor_q,  divisor_d;
  logic                  neg_quot_q, neg_quot_d;
  logic                  neg_rem_q,  neg_rem_d;
  logic [2*DATA_W-1:0]   result_q,   result_d;
  logic                  ready_q,    ready_d;
`ifdef DIV_BYZERO_FLAG_EN
  logic                  divzero_q,  divzero_d;
`endif

  // Operand magnitudes, only negated for signed ops with a negative operand
  logic              op1_neg_c, op2_neg_c;
  logic [DATA_W-1:0] op1_mag_c, op2_mag_c;

  always_comb begin
    op1_neg_c = signed_div_i & opdata1_i[DATA_W-1];
    op2_neg_c = signed_div_i & opdata2_i[DATA_W-1];
    op1_mag_c = op1_neg_c ? (~opdata1_i + DATA_W'(1)) : opdata1_i;
    op2_mag_c = op2_neg_c ? (~opdata2_i + DATA_W'(1)) : opdata2_i;
  end

  // One restoring step: bring down the next dividend bit and trial-subtract the divisor
  logic [DATA_W:0]   minuend_c;
  logic [DATA_W+1:0] trial_c;
  logic              borrow_c;
  logic [DATA_W-1:0] step_rem_c;
  logic [DATA_W-1:0] step_quot_c;

  always_comb begin
    minuend_c   = {rem_q, quot_q[DATA_W-1]};
    trial_c     = {1'b0, minuend_c} - {2'b00, divisor_q};
    borrow_c    = trial_c[DATA_W+1];
    step_rem_c  = borrow_c ? DATA_W'(minuend_c) : DATA_W'(trial_c);
    step_quot_c = {quot_q[DATA_W-2:0], ~borrow_c};
  end

  // Sign fix-up applied when the magnitude result is complete
  logic [DATA_W-1:0] fix_quot_c;
  logic [DATA_W-1:0] fix_rem_c;

  always_comb begin
    fix_quot_c = neg_quot_q ? (~quot_q + DATA_W'(1)) : quot_q;
    fix_rem_c  = neg_rem_q  ? (~rem_q  + DATA_W'(1)) : rem_q;
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    quot_d     = quot_q;
    rem_d      = rem_q;
    divisor_d  = divisor_q;
    neg_quot_d = neg_quot_q;
    neg_rem_d  = neg_rem_q;
    result_d   = result_q;
    ready_d    = ready_q;
`ifdef DIV_BYZERO_FLAG_EN
    divzero_d  = divzero_q;
`endif

    unique case (state_q)
      S_FREE: begin
        if (start_i && !annul_i) begin
          if (opdata2_i == '0) begin
            state_d = S_BYZERO;
          end else begin
            state_d    = S_ON;
            cnt_d      = '0;
            quot_d     = op1_mag_c;
            rem_d      = '0;
            divisor_d  = op2_mag_c;
            neg_quot_d = op1_neg_c ^ op2_neg_c;
            neg_rem_d  = op1_neg_c;
          end
        end
      end

      S_BYZERO: begin
        state_d  = S_END;
        result_d = '0;
        ready_d  = 1'b1;
`ifdef DIV_BYZERO_FLAG_EN
        divzero_d = 1'b1;
`endif
      end

      S_ON: begin
        if (annul_i) begin
          state_d = S_FREE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(DATA_W)) begin
          state_d  = S_END;
          result_d = {fix_rem_c, fix_quot_c};
          ready_d  = 1'b1;
        end else begin
          quot_d = step_quot_c;
          rem_d  = step_rem_c;
          cnt_d  = cnt_q + CNT_W'(1);
        end
      end

      S_END: begin
        // EX holds start_i until it has consumed the result
        if (!start_i || annul_i) begin
          state_d  = S_FREE;
          result_d = '0;
          ready_d  = 1'b0;
`ifdef DIV_BYZERO_FLAG_EN
          divzero_d = 1'b0;
`endif
        end
      end

      default: begin
        state_d = S_FREE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_FREE;
      cnt_q      <= '0;
      quot_q     <= '0;
      rem_q      <= '0;
      divisor_q  <= '0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      result_q   <= '0;
      ready_q    <= 1'b0;
`ifdef DIV_BYZERO_FLAG_EN
      divzero_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      quot_q     <= quot_d;
      rem_q      <= rem_d;
      divisor_q  <= divisor_d;
      neg_quot_q <= neg_quot_d;
      neg_rem_q  <= neg_rem_d;
      result_q   <= result_d;
      ready_q    <= ready_d;
`ifdef DIV_BYZERO_FLAG_EN
      divzero_q  <= divzero_d;
`endif
    end
  end

  assign result_o = result_q;
  assign ready_o  = ready_q;
`ifdef DIV_BYZERO_FLAG_EN
  assign divzero_o = divzero_q;
`endif

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: the driver queues expected results, a negedge monitor checks them.
module tb_div_unit;

  localparam int unsigned W = 32;

  logic           clk = 1'b0;
  logic           rst;
  logic           signed_div;
  logic [W-1:0]   op1;
  logic [W-1:0]   op2;
  logic           start;
  logic           annul;
  logic [2*W-1:0] result;
  logic           ready;
`ifdef DIV_BYZERO_FLAG_EN
  logic           divzero;
`endif

  div_unit #(.DATA_W(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div),
    .opdata1_i    (op1),
    .opdata2_i    (op2),
    .start_i      (start),
    .annul_i      (annul),
    .result_o     (result),
    .ready_o      (ready)
`ifdef DIV_BYZERO_FLAG_EN
    ,
    .divzero_o    (divzero)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2*W-1:0] res;
    int             e0;
    int             lat;
    logic           dz;
  } exp_t;

  exp_t sb_q[$];
  int   cyc    = 0;
  int   n_vec  = 0;
  int   n_err  = 0;
  int   n_rise = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: each rising ready_o pops one expectation; result must hold while ready_o stays high
  initial begin
    logic           prev;
    logic [2*W-1:0] held;
    exp_t           e;
    prev = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev = 1'b0;
      end else begin
        if (ready && !prev) begin
          n_rise++;
          n_vec++;
          if (sb_q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_ready: result=%h with no pending op", result);
          end else begin
            e = sb_q.pop_front();
            if (result !== e.res) begin
              n_err++;
              $display("FAIL result: got %h expected %h", result, e.res);
            end
            n_vec++;
            if (cyc - e.e0 != e.lat) begin
              n_err++;
              $display("FAIL latency: got E%0d expected E%0d", cyc - e.e0, e.lat);
            end
`ifdef DIV_BYZERO_FLAG_EN
            n_vec++;
            if (divzero !== e.dz) begin
              n_err++;
              $display("FAIL divzero: got %b expected %b", divzero, e.dz);
            end
`endif
          end
          held = result;
        end else if (ready && prev) begin
          n_vec++;
          if (result !== held) begin
            n_err++;
            $display("FAIL hold: got %h expected %h", result, held);
          end
        end
        prev = ready;
      end
    end
  end

  // Called at a negedge; issues one op, waits for ready, holds two cycles, releases, checks release
  task automatic run_op(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [2*W-1:0] exp_res, input int lat);
    exp_t e;
    logic got;
    signed_div = sgn;
    op1        = a;
    op2        = b;
    start      = 1'b1;
    e.res = exp_res;
    e.e0  = cyc + 1;
    e.lat = lat;
    e.dz  = (b == '0);
    sb_q.push_back(e);
    got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if (i == 0) begin
        // operands must not be re-sampled once the op is accepted
        op1        = ~a;
        op2        = b + 32'd3;
        signed_div = ~sgn;
      end
      if (ready) got = 1'b1;
    end
    n_vec++;
    if (!got) begin
      n_err++;
      $display("FAIL timeout: a=%h b=%h no ready_o within 100 cycles", a, b);
      sb_q.delete();
    end
    repeat (2) @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    n_vec++;
    if (ready !== 1'b0 || result !== '0) begin
      n_err++;
      $display("FAIL release: ready=%b result=%h expected ready=0 result=0", ready, result);
    end
  endtask

  task automatic check_idle(input int rises0, input string name);
    repeat (40) @(negedge clk);
    n_vec++;
    if (n_rise != rises0) begin
      n_err++;
      $display("FAIL %s: ready_o rose %0d times, expected 0", name, n_rise - rises0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int rises0;
    exp_t e;
    rst        = 1'b1;
    start      = 1'b0;
    annul      = 1'b0;
    signed_div = 1'b0;
    op1        = '0;
    op2        = '0;
    repeat (3) @(negedge clk);
    n_vec++;
    if (ready !== 1'b0 || result !== '0) begin
      n_err++;
      $display("FAIL reset_state: ready=%b result=%h expected 0/0", ready, result);
    end
    rst = 1'b0;
    @(negedge clk);

    run_op(1'b0, 32'd100,      32'd7,      {32'd2,        32'd14},       33);
    run_op(1'b1, 32'hFFFFFFF9, 32'd2,      {32'hFFFFFFFF, 32'hFFFFFFFD}, 33);
    run_op(1'b1, 32'd7,        32'hFFFFFFFE, {32'h00000001, 32'hFFFFFFFD}, 33);
    run_op(1'b1, 32'h80000000, 32'hFFFFFFFF, {32'h00000000, 32'h80000000}, 33);
    run_op(1'b0, 32'd5,        32'd0,      64'd0,                         1);
    run_op(1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9, {32'hFFFFFFFE, 32'h0000000E}, 33);
    run_op(1'b0, 32'hFFFFFFFF, 32'd1,      {32'd0,        32'hFFFFFFFF}, 33);
    run_op(1'b0, 32'hFFFFFFFF, 32'h10,     {32'h0000000F, 32'h0FFFFFFF}, 33);
    run_op(1'b0, 32'd3,        32'd7,      {32'd3,        32'd0},        33);
    run_op(1'b1, 32'h80000000, 32'd2,      {32'd0,        32'hC0000000}, 33);
    run_op(1'b0, 32'h80000000, 32'hFFFFFFFF, {32'h80000000, 32'd0},      33);
    run_op(1'b1, 32'hFFFFFFF9, 32'd0,      64'd0,                         1);
    run_op(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, {32'd0,        32'd1},        33);
    run_op(1'b1, 32'h12345678, 32'h100,    {32'h00000078, 32'h00123456}, 33);

    // Flush at cnt=10: annul pulse on the edge after E10, result never delivered
    rises0     = n_rise;
    signed_div = 1'b0;
    op1        = 32'd1000;
    op2        = 32'd3;
    start      = 1'b1;
    repeat (11) @(negedge clk);
    annul = 1'b1;
    start = 1'b0;
    @(negedge clk);
    annul = 1'b0;
    check_idle(rises0, "annul_no_ready");
    run_op(1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 33);

    // Reset at cnt=20
    rises0 = n_rise;
    op1    = 32'd100;
    op2    = 32'd7;
    start  = 1'b1;
    repeat (21) @(negedge clk);
    rst   = 1'b1;
    start = 1'b0;
    @(negedge clk);
    n_vec++;
    if (ready !== 1'b0 || result !== '0) begin
      n_err++;
      $display("FAIL rst_mid_op: ready=%b result=%h expected 0/0", ready, result);
    end
    rst = 1'b0;
    check_idle(rises0, "rst_no_ready");

    // Reset while holding a result in END clears the outputs
    signed_div = 1'b0;
    op1        = 32'd50;
    op2        = 32'd6;
    start      = 1'b1;
    e.res = {32'd2, 32'd8};
    e.e0  = cyc + 1;
    e.lat = 33;
    e.dz  = 1'b0;
    sb_q.push_back(e);
    repeat (36) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_vec++;
    if (ready !== 1'b0 || result !== '0) begin
      n_err++;
      $display("FAIL rst_in_end: ready=%b result=%h expected 0/0", ready, result);
    end
    rst   = 1'b0;
    start = 1'b0;
    repeat (2) @(negedge clk);

    run_op(1'b1, 32'd100, 32'd7, {32'd2, 32'd14}, 33);

    repeat (5) @(negedge clk);
    n_vec++;
    if (sb_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: %0d results outstanding, expected 0", sb_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
